mem_port_arbiter: RTL and testbench

Shares the single unified memory port between the core's instruction-fetch path, its data load/store path and a write-only program loader. Each request becomes one memory transaction, sequenced by an FSM that handles fixed memory read latency. The block also produces the stall that holds the single-cycle core's PC and register writeback. It sits between the processor's `inst`/`pc` and `addr`/`wdata`/`wmask`/`rdata` ports and the memory model.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch, data and loader requests onto one fixed-latency memory port.
// Optional ARB_RR_EN: round-robin between data and fetch (loader keeps top priority).
// state | meaning
// IDLE  | arbitrate pending requests, latch winner into issue registers
// ISSUE | mem_req strobe for exactly one cycle
// WAIT  | read latency countdown, capture mem_rdata at zero
// DONE  | one-cycle done pulse to the winner
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_done,
  input  logic        ld_req,
  input  logic [31:0] ld_addr,
  input  logic [63:0] ld_wdata,
  input  logic [7:0]  ld_wmask,
  output logic        ld_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  output logic        stall
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {ID_IF, ID_D, ID_LD} id_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t      state_q, state_d;
  id_t         id_q, id_d, gnt_id;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mem_req_q, if_done_q, d_done_q, ld_done_q;
  logic        any_req;

  assign any_req = ld_req | d_req | if_req;

`ifdef ARB_RR_EN
  logic last_d_q;  // 1 = data won the last data/fetch grant
`endif

  always_comb begin
    gnt_id = ID_IF;
    if (ld_req) gnt_id = ID_LD;
`ifdef ARB_RR_EN
    else if (d_req && !(if_req && last_d_q)) gnt_id = ID_D;
`else
    else if (d_req) gnt_id = ID_D;
`endif
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          id_d    = gnt_id;
          state_d = S_ISSUE;
          case (gnt_id)
            ID_LD: begin
              we_d = 1'b1; addr_d = ld_addr; wdata_d = ld_wdata; wmask_d = ld_wmask;
            end
            ID_D: begin
              we_d = d_we; addr_d = d_addr; wdata_d = d_wdata; wmask_d = d_wmask;
            end
            default: begin
              we_d = 1'b0; addr_d = if_addr; wdata_d = '0; wmask_d = '0;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          rdata_d = mem_rdata;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Done pulses and strobe are flopped from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= S_IDLE;
      id_q      <= ID_IF;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      mem_req_q <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      ld_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      mem_req_q <= (state_d == S_ISSUE);
      if_done_q <= (state_d == S_DONE) && (id_q == ID_IF);
      d_done_q  <= (state_d == S_DONE) && (id_q == ID_D);
      ld_done_q <= (state_d == S_DONE) && (id_q == ID_LD);
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (nrst) last_d_q <= 1'b0;
    else if ((state_q == S_IDLE) && any_req && !ld_req) last_d_q <= (gnt_id == ID_D);
  end
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign if_rdata  = rdata_q;
  assign d_rdata   = rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;
  assign ld_done   = ld_done_q;
  assign stall     = (if_req & ~if_done_q) | (d_req & ~d_done_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: MEM_LAT=2 and MEM_LAT=7 instances share requester stimulus;
// a scoreboard of expected done pulses is compared against each instance's outputs.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        nrst;
  logic        if_req, d_req, d_we, ld_req;
  logic [31:0] if_addr, d_addr, ld_addr;
  logic [63:0] d_wdata, ld_wdata;
  logic [7:0]  d_wmask, ld_wmask;

  logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_rdata2;
  logic        if_done2, d_done2, ld_done2, mem_req2, mem_we2, stall2;
  logic [63:0] mem_wdata2;
  logic [7:0]  mem_wmask2;

  logic [31:0] if_rdata7, d_rdata7, mem_addr7, mem_rdata7;
  logic        if_done7, d_done7, ld_done7, mem_req7, mem_we7, stall7;
  logic [63:0] mem_wdata7;
  logic [7:0]  mem_wmask7;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.MEM_LAT(2)) dut2 (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata2), .if_done(if_done2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata2), .d_done(d_done2),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wmask(ld_wmask),
    .ld_done(ld_done2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_wmask(mem_wmask2), .mem_rdata(mem_rdata2), .stall(stall2)
  );

  mem_port_arbiter #(.MEM_LAT(7)) dut7 (
    .clk(clk), .nrst(nrst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata7), .if_done(if_done7),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rdata(d_rdata7), .d_done(d_done7),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wmask(ld_wmask),
    .ld_done(ld_done7),
    .mem_req(mem_req7), .mem_we(mem_we7), .mem_addr(mem_addr7), .mem_wdata(mem_wdata7),
    .mem_wmask(mem_wmask7), .mem_rdata(mem_rdata7), .stall(stall7)
  );

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    if (a == 32'h10) return 32'h00500093;
    return a * 32'h9E3779B1 + 32'h1;
  endfunction

  // Memory model: read data is valid only in the exact cycle MEM_LAT after mem_req.
  logic [7:0]        v2 = '0, v7 = '0;
  logic [7:0][31:0]  a2 = '0, a7 = '0;
  always @(posedge clk) begin
    v2 <= {v2[6:0], mem_req2};
    a2 <= {a2[6:0], mem_addr2};
    v7 <= {v7[6:0], mem_req7};
    a7 <= {a7[6:0], mem_addr7};
  end
  assign mem_rdata2 = v2[1] ? rd_fn(a2[1]) : 32'hBAD0BAD0;
  assign mem_rdata7 = v7[6] ? rd_fn(a7[6]) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic        rd;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t sb2[$];
  exp_t sb7[$];
  bit mon2_en = 1'b1;
  bit mon7_en = 1'b0;

  task automatic push2(input int id, input logic rd, input logic [31:0] data, input int at);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data; e.at = at;
    sb2.push_back(e);
  endtask

  task automatic push7(input int id, input logic rd, input logic [31:0] data, input int at);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data; e.at = at;
    sb7.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon2_en && (if_done2 | d_done2 | ld_done2)) begin
      chk("done2_onehot", 64'($countones({if_done2, d_done2, ld_done2})), 64'd1);
      chk("done2_expected", 64'(sb2.size() != 0), 64'd1);
      if (sb2.size() != 0) begin
        exp_t e;
        e = sb2.pop_front();
        chk("done2_id", 64'(ld_done2 ? 2 : (d_done2 ? 1 : 0)), 64'(e.id));
        chk("done2_cycle", 64'(cyc), 64'(e.at));
        if (e.rd) chk("done2_rdata", 64'(d_done2 ? d_rdata2 : if_rdata2), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (mon7_en && (if_done7 | d_done7 | ld_done7)) begin
      chk("done7_expected", 64'(sb7.size() != 0), 64'd1);
      if (sb7.size() != 0) begin
        exp_t e;
        e = sb7.pop_front();
        chk("done7_id", 64'(ld_done7 ? 2 : (d_done7 ? 1 : 0)), 64'(e.id));
        chk("done7_cycle", 64'(cyc), 64'(e.at));
        if (e.rd) chk("done7_rdata", 64'(d_rdata7), 64'(e.data));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b1;
    next_cycle();
    nrst = 1'b0;
  endtask

  function automatic logic done_sel(input int which);
    if (which == 2) return ld_done2;
    if (which == 1) return d_done2;
    return if_done2;
  endfunction

  task automatic wait_done(input int which, input int budget);
    int k = 0;
    #2;
    while (!done_sel(which) && k < budget) begin
      next_cycle();
      #2;
      k++;
    end
    chk("wait_done", 64'(done_sel(which)), 64'd1);
  endtask

  task automatic drain2(input int budget);
    int k = 0;
    while (sb2.size() != 0 && k < budget) begin
      next_cycle();
      k++;
    end
    chk("sb2_drained", 64'(sb2.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    nrst = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; ld_req = 0;
    if_addr = '0; d_addr = '0; ld_addr = '0;
    d_wdata = '0; ld_wdata = '0; d_wmask = '0; ld_wmask = '0;
    repeat (3) next_cycle();
    #2;
    chk("rst_mem_req", 64'(mem_req2), 64'd0);
    chk("rst_dones", 64'({if_done2, d_done2, ld_done2}), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr2), 64'd0);
    chk("rst_rdata", 64'(if_rdata2), 64'd0);
    chk("rst_stall", 64'(stall2), 64'd0);
    next_cycle();
    nrst = 1'b0;
    next_cycle();

    // Fetch read, MEM_LAT=2
    if_req = 1; if_addr = 32'h10; n = cyc;
    push2(0, 1'b1, 32'h00500093, n + 4);
    #2;
    chk("f_stall_n", 64'(stall2), 64'd1);
    chk("f_mem_req_n", 64'(mem_req2), 64'd0);
    next_cycle(); #2;
    chk("f_mem_req_n1", 64'(mem_req2), 64'd1);
    chk("f_mem_addr", 64'(mem_addr2), 64'h10);
    chk("f_mem_we", 64'(mem_we2), 64'd0);
    chk("f_stall_n1", 64'(stall2), 64'd1);
    next_cycle(); #2;
    chk("f_mem_req_n2", 64'(mem_req2), 64'd0);
    chk("f_stall_n2", 64'(stall2), 64'd1);
    next_cycle(); #2;
    chk("f_stall_n3", 64'(stall2), 64'd1);
    next_cycle(); #2;
    chk("f_if_done_n4", 64'(if_done2), 64'd1);
    chk("f_if_rdata", 64'(if_rdata2), 64'h00500093);
    chk("f_stall_n4", 64'(stall2), 64'd0);
    next_cycle();
    if_req = 0;
    next_cycle();

    // Store, write completes at N+2 with no read capture
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 64'hDEADBEEF; d_wmask = 8'h0F;
    n = cyc;
    push2(1, 1'b0, 32'h0, n + 2);
    next_cycle(); #2;
    chk("s_mem_req", 64'(mem_req2), 64'd1);
    chk("s_mem_we", 64'(mem_we2), 64'd1);
    chk("s_mem_addr", 64'(mem_addr2), 64'h100);
    chk("s_mem_wdata", mem_wdata2, 64'hDEADBEEF);
    chk("s_mem_wmask", 64'(mem_wmask2), 64'h0F);
    next_cycle(); #2;
    chk("s_d_done", 64'(d_done2), 64'd1);
    chk("s_no_capture", 64'(d_rdata2), 64'h00500093);
    next_cycle();
    d_req = 0; d_we = 0;
    #2;
    chk("s_issue_hold_we", 64'(mem_we2), 64'd1);
    chk("s_issue_hold_addr", 64'(mem_addr2), 64'h100);

    do_reset();
    next_cycle();

    // All three requesters at once: ld, then d, then if
    ld_req = 1; ld_addr = 32'h200; ld_wdata = 64'h1122334455667788; ld_wmask = 8'hFF;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    if_req = 1; if_addr = 32'h20;
    n = cyc;
    push2(2, 1'b0, 32'h0, n + 2);
    push2(1, 1'b1, rd_fn(32'h300), n + 7);
    push2(0, 1'b1, rd_fn(32'h20), n + 12);
    next_cycle(); #2;
    chk("p_ld_we", 64'(mem_we2), 64'd1);
    chk("p_ld_addr", 64'(mem_addr2), 64'h200);
    chk("p_ld_wdata", mem_wdata2, 64'h1122334455667788);
    wait_done(2, 20);
    next_cycle(); ld_req = 0;
    wait_done(1, 20);
    next_cycle(); d_req = 0;
    wait_done(0, 20);
    next_cycle(); if_req = 0;
    chk("p_sb_empty", 64'(sb2.size()), 64'd0);
    next_cycle();

    // Data and fetch held continuously
    d_req = 1; d_we = 0; d_addr = 32'h400;
    if_req = 1; if_addr = 32'h20;
    n = cyc;
`ifdef ARB_RR_EN
    push2(1, 1'b1, rd_fn(32'h400), n + 4);
    push2(0, 1'b1, rd_fn(32'h20), n + 9);
    push2(1, 1'b1, rd_fn(32'h400), n + 14);
    push2(0, 1'b1, rd_fn(32'h20), n + 19);
`else
    push2(1, 1'b1, rd_fn(32'h400), n + 4);
    push2(1, 1'b1, rd_fn(32'h400), n + 9);
    push2(1, 1'b1, rd_fn(32'h400), n + 14);
    push2(1, 1'b1, rd_fn(32'h400), n + 19);
`endif
    drain2(40);
    #2;
    chk("h_stall_held", 64'(stall2), 64'd1);
    d_req = 0; if_req = 0;
    next_cycle();

    // Reset while in WAIT abandons the fetch
    if_req = 1; if_addr = 32'h30;
    next_cycle(); #2;
    chk("r_mem_req_issue", 64'(mem_req2), 64'd1);
    next_cycle();
    nrst = 1; if_req = 0;
    #2;
    chk("r_mem_req_wait", 64'(mem_req2), 64'd0);
    next_cycle();
    nrst = 0;
    #2;
    chk("r_mem_req_after", 64'(mem_req2), 64'd0);
    chk("r_mem_addr_after", 64'(mem_addr2), 64'd0);
    chk("r_rdata_after", 64'(if_rdata2), 64'd0);
    chk("r_no_done", 64'({if_done2, d_done2, ld_done2}), 64'd0);
    repeat (4) next_cycle();
    #2;
    chk("r_idle_quiet", 64'({mem_req2, if_done2}), 64'd0);
    next_cycle();
    if_req = 1; if_addr = 32'h10; n = cyc;
    push2(0, 1'b1, 32'h00500093, n + 4);
    wait_done(0, 20);
    next_cycle(); if_req = 0;
    chk("r_fresh_sb_empty", 64'(sb2.size()), 64'd0);

    // MEM_LAT=7 data read
    mon2_en = 1'b0;
    do_reset();
    next_cycle();
    mon7_en = 1'b1;
    d_req = 1; d_we = 0; d_addr = 32'h500; n = cyc;
    push7(1, 1'b1, rd_fn(32'h500), n + 9);
    next_cycle(); #2;
    chk("l7_mem_req", 64'(mem_req7), 64'd1);
    begin
      int k = 0;
      while (sb7.size() != 0 && k < 30) begin
        next_cycle();
        k++;
      end
    end
    chk("l7_sb_empty", 64'(sb7.size()), 64'd0);
    d_req = 0;
    repeat (3) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
